// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the serial pattern detector.
// Build option: SEQ_DETECT_OVERLAP_EN selects overlapping detection (see seq_detect_ctrl).
package seq_detect_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_shift_cmp.sv
// Serial shift window plus masked compare of the window that includes the current bit.
// The match output is combinational and reflects the window {shift_q[PAT_W-2:0], din}.
module seq_shift_cmp
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   input  logic [PAT_W-1:0] pattern,
   input  logic [PAT_W-1:0] mask,
   output logic [PAT_W-1:0] shift_q,
   output logic             match
);

   logic [PAT_W-1:0] shift_reg;
   logic [PAT_W-1:0] window;
   logic [PAT_W-1:0] diff;

   assign window = {shift_reg[PAT_W-2:0], din};

   // Only bits selected by the mask can disqualify a match.
   generate
      for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
         assign diff[gi] = mask[gi] & (window[gi] ^ pattern[gi]);
      end
   endgenerate

   assign match   = (diff == '0);
   assign shift_q = shift_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_reg <= '0;
      end else if (clr) begin
         shift_reg <= '0;
      end else if (shift_en) begin
         shift_reg <= window;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: config handshake, ARM/RUN FSM and saturating match counter.
// Build option: define SEQ_DETECT_OVERLAP_EN to keep detecting in RUN after a match.
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [PAT_W-1:0] cfg_mask,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             match_pulse,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [PAT_W-1:0] shift_q
);

`ifdef SEQ_DETECT_OVERLAP_EN
   localparam bit OVERLAP_EN = 1'b1;
`else
   localparam bit OVERLAP_EN = 1'b0;
`endif

   localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W - 1) : 1;
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);

   state_t           state_reg;
   logic [PAT_W-1:0] pattern_reg;
   logic [PAT_W-1:0] mask_reg;
   logic [CNT_W-1:0] target_reg;
   logic [FILL_W-1:0] fill_reg;
   logic [CNT_W-1:0] match_cnt_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             match_pulse_reg;

   logic             idle_or_done;
   logic             cfg_fire;
   logic             start_acc;
   logic             cmp_match;
   logic             run_match;
   logic [CNT_W-1:0] cnt_next;
   logic             final_match;
   logic             shift_clr;
   logic             shift_en;

   assign idle_or_done = (state_reg == S_IDLE) || (state_reg == S_DONE);
   assign cfg_fire     = cfg_valid && idle_or_done;
   assign start_acc    = start && idle_or_done;

   // stop wins over a match completing in the same cycle
   assign run_match   = (state_reg == S_RUN) && cmp_match && !stop;
   assign cnt_next    = (match_cnt_reg == '1) ? match_cnt_reg : match_cnt_reg + CNT_W'(1);
   assign final_match = run_match && (target_reg != '0) && (cnt_next == target_reg);

   assign shift_en  = (state_reg == S_ARM) || (state_reg == S_RUN);
   assign shift_clr = start_acc || (run_match && !final_match && !OVERLAP_EN);

   seq_shift_cmp #(
      .PAT_W (PAT_W)
   ) u_shift_cmp (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (shift_clr),
      .shift_en (shift_en),
      .din      (din),
      .pattern  (pattern_reg),
      .mask     (mask_reg),
      .shift_q  (shift_q),
      .match    (cmp_match)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         pattern_reg     <= '0;
         mask_reg        <= '0;
         target_reg      <= '0;
         fill_reg        <= '0;
         match_cnt_reg   <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         match_pulse_reg <= 1'b0;
      end else begin
         match_pulse_reg <= 1'b0;

         if (cfg_fire) begin
            pattern_reg <= cfg_pattern;
            mask_reg    <= cfg_mask;
            target_reg  <= cfg_target;
         end

         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_reg     <= S_ARM;
                  busy_reg      <= 1'b1;
                  done_reg      <= 1'b0;
                  match_cnt_reg <= '0;
                  fill_reg      <= '0;
               end
            end
            S_ARM: begin
               if (stop) begin
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
               end else if (fill_reg == FILL_LAST) begin
                  state_reg <= S_RUN;
               end else begin
                  fill_reg <= fill_reg + FILL_W'(1);
               end
            end
            S_RUN: begin
               if (stop) begin
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
               end else if (run_match) begin
                  match_pulse_reg <= 1'b1;
                  match_cnt_reg   <= cnt_next;
                  if (final_match) begin
                     state_reg <= S_DONE;
                     busy_reg  <= 1'b0;
                     done_reg  <= 1'b1;
                  end else if (!OVERLAP_EN) begin
                     state_reg <= S_ARM;
                     fill_reg  <= '0;
                  end
               end
            end
            default: begin
               state_reg <= S_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready   = idle_or_done;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign match_pulse = match_pulse_reg;
   assign match_cnt   = match_cnt_reg;

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern/window width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: match counter and target width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port din  input  1  serial data bit, sampled every clk.
REQ-006 SHALL have port cfg_valid  input  1  config request.
REQ-007 SHALL have port cfg_ready  output  1  config accepted when cfg_valid&&cfg_ready.
REQ-008 SHALL have port cfg_pattern  input  PAT_W  target pattern, MSB = oldest bit.
REQ-009 SHALL have port cfg_mask  input  PAT_W  1 = compare bit, 0 = don't care.
REQ-010 SHALL have port cfg_target  input  CNT_W  match count ending the run; 0 = free-run.
REQ-011 SHALL have port start  input  1  begin detection run.
REQ-012 SHALL have port stop  input  1  abort run.
REQ-013 SHALL have port busy  output  1  high in ARM/RUN.
REQ-014 SHALL have port match_pulse  output  1  one-cycle pulse per match.
REQ-015 SHALL have port done  output  1  level, high in DONE.
REQ-016 SHALL have port match_cnt  output  CNT_W  matches in current/last run.
REQ-017 SHALL have port shift_q  output  PAT_W  current shift window, LSB = newest bit.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, RUN, DONE.
REQ-019 SHALL drive cfg_ready=1 only in IDLE/DONE; handshake latches pattern, mask, target.
REQ-020 SHALL, on start in IDLE/DONE, go to ARM next cycle: clear shift_q, match_cnt, done, fill counter.
REQ-021 SHALL, when cfg handshake and start coincide, run with the newly latched config.
REQ-022 SHALL ignore start while busy; ignore cfg_valid while busy.
REQ-023 SHALL shift shift_q <= {shift_q[PAT_W-2:0], din} every cycle in ARM/RUN; hold in IDLE/DONE.
REQ-024 SHALL stay in ARM for exactly PAT_W-1 cycles, then enter RUN.
REQ-025 SHALL in RUN evaluate window w = {shift_q[PAT_W-2:0], din}; match when (w & mask) == (pattern & mask).
REQ-026 SHALL assert match_pulse and increment match_cnt in the cycle after the completing bit (latency 1).
REQ-027 SHALL saturate match_cnt at all-ones; no wrap.
REQ-028 SHALL enter DONE when match_cnt reaches nonzero cfg_target; done=1 and busy=0 same cycle as last match_pulse.
REQ-029 SHALL never leave RUN by count when cfg_target=0.
REQ-030 SHALL, on stop in ARM/RUN, go to IDLE next cycle; stop overrides a same-cycle match (no pulse, no increment); match_cnt retained.
REQ-031 SHALL treat mask=0 as match-every-cycle in RUN.

Reset
REQ-032 SHALL, with rst_n=0 at posedge clk, set state IDLE, busy=0, done=0, match_pulse=0, match_cnt=0, shift_q=0, pattern=0, mask=0, target=0.
REQ-033 SHALL honour reset mid-run: abort with no further match_pulse.

Configuration
REQ-034 SHALL use macro SEQ_DETECT_OVERLAP_EN.
REQ-035 SHALL, with SEQ_DETECT_OVERLAP_EN defined, stay in RUN after a match (overlapping detection).
REQ-036 SHALL, without it, after a non-final match clear shift_q and return to ARM (PAT_W-1 refill bits; non-overlapping).

Structure
REQ-037 SHALL place the state enum and default PAT_W/CNT_W constants in package seq_detect_pkg.
REQ-038 SHALL use one sub-module seq_shift_cmp (shift register + masked compare); FSM and counter stay in the top.

Verification
REQ-039 Overlap on: pattern 1011, mask 1111, target 2, din 1,0,1,1,0,1,1 -> pulses after bits 4 and 7; done=1, match_cnt=2.
REQ-040 Overlap off, same stimulus, target 0 -> one pulse after bit 4; match_cnt=1.
REQ-041 Mask 1001, pattern 1001, din 1,1,1,1 -> pulse after bit 4.
REQ-042 stop in the same cycle as completing bit of 1011 -> no pulse, IDLE next cycle, match_cnt unchanged.
REQ-043 start+cfg_valid same cycle in DONE with new pattern 0110 -> cfg accepted, ARM next cycle, old pattern not matched.
REQ-044 CNT_W=2, target 0, mask 0000, 6 RUN cycles -> match_cnt saturates at 3, busy stays 1.
